servo_seq_pwm: RTL and testbench

//  Drives the two continuous-rotation drive servos (left/right) from a queue of motion segments.

---
 rtl/servo_pkg.sv | 33 +++
 rtl/servo_pwm_ch.sv | 27 ++
 rtl/servo_seq_pwm.sv | 166 ++++++++++++++++
 tb/tb_servo_seq_pwm.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the servo segment sequencer: direction codes,
// default pulse widths and the direction-to-pulse-width map.
package servo_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_STOP = 2'b00;
    localparam dir_t DIR_FWD  = 2'b01;
    localparam dir_t DIR_REV  = 2'b10;
    localparam dir_t DIR_SPIN = 2'b11;

    localparam int unsigned PULSE_POS_DEF = 150_000;
    localparam int unsigned PULSE_NEG_DEF = 157_000;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    // The servos face opposite ways, so "forward" needs opposite rotations per side.
    function automatic logic [31:0] dir_width(input dir_t dir, input logic right,
                                              input logic [31:0] pos, input logic [31:0] neg);
        logic [31:0] w;
        case (dir)
            DIR_FWD:  w = right ? pos : neg;
            DIR_REV:  w = right ? neg : pos;
            DIR_SPIN: w = pos;
            default:  w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One PWM output: compares the upcoming frame count against the upcoming width
// so the registered pin lines up exactly with the shared frame counter.
module servo_pwm_ch
    import servo_pkg::*;
#(
    parameter int unsigned CNT_W = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] i_cnt_next,
    input  logic [CNT_W-1:0] i_width,
    output logic             o_pwm
);

    logic r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (i_cnt_next < i_width);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/servo_seq_pwm.sv
// Replays queued {direction, frames} motion segments onto the left/right servo
// PWM pins, switching segments only on frame boundaries.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no active segment, pins held low, pop on next frame_tick
//   ST_RUN  | segment active, r_rem frames left including the current one
module servo_seq_pwm
    import servo_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = 2_000_000,
    parameter int unsigned PULSE_POS  = PULSE_POS_DEF,
    parameter int unsigned PULSE_NEG  = PULSE_NEG_DEF,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DUR_W      = 12,
    parameter int unsigned CNT_W      = 22
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_dir,
    input  logic [DUR_W-1:0]         cmd_frames,
    input  logic                     abort,
    output logic                     signal_left,
    output logic                     signal_right,
    output logic                     busy,
    output logic                     seg_done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     frame_tick
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = DUR_W + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

    logic [CNT_W-1:0] r_frame_cnt;
    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    state_t           r_state;
    dir_t             r_dir;
    logic [DUR_W-1:0] r_rem;
    logic             r_abort_pend;
    logic             r_seg_done;

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_tick;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_seg_last;
    logic             w_abort_any;
    logic             w_boundary;
    dir_t             w_head_dir;
    logic [DUR_W-1:0] w_head_frames;
    dir_t             w_dir_next;
    logic [CNT_W-1:0] w_width_l;
    logic [CNT_W-1:0] w_width_r;

    assign w_tick     = (r_frame_cnt == LAST_CNT);
    assign w_cnt_next = w_tick ? '0 : r_frame_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= w_cnt_next;
        end
    end

    assign cmd_ready = (r_count < FULL_CNT) && !abort;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_empty   = (r_count == '0);
    assign {w_head_dir, w_head_frames} = r_mem[r_rd_ptr];

    // A segment ends on the tick when it runs out or an abort is pending; a new
    // one is only pulled in if no abort is in flight, so an abort always idles.
    assign w_seg_last  = (r_state == ST_RUN) && (r_rem == DUR_W'(1));
    assign w_abort_any = abort || r_abort_pend;
    assign w_boundary  = w_tick && ((r_state == ST_IDLE) || w_seg_last || w_abort_any);
    assign w_pop       = w_boundary && !w_empty && !w_abort_any;
    assign w_dir_next  = w_pop ? w_head_dir : (w_boundary ? DIR_STOP : r_dir);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_dir, cmd_frames};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_STOP;
            r_rem        <= '0;
            r_abort_pend <= 1'b0;
            r_seg_done   <= 1'b0;
        end else begin
            r_seg_done <= w_tick && w_seg_last && !w_abort_any;
            if (w_pop) begin
                r_state <= ST_RUN;
                r_dir   <= w_head_dir;
                r_rem   <= (w_head_frames == '0) ? DUR_W'(1) : w_head_frames;
            end else if (w_boundary) begin
                r_state <= ST_IDLE;
                r_dir   <= DIR_STOP;
                r_rem   <= '0;
            end else if (w_tick && (r_state == ST_RUN)) begin
                r_rem <= r_rem - DUR_W'(1);
            end
            if (w_boundary) begin
                r_abort_pend <= 1'b0;
            end else if (abort && (r_state == ST_RUN)) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

    assign w_width_l = CNT_W'(dir_width(w_dir_next, 1'b0, 32'(PULSE_POS), 32'(PULSE_NEG)));
    assign w_width_r = CNT_W'(dir_width(w_dir_next, 1'b1, 32'(PULSE_POS), 32'(PULSE_NEG)));

    servo_pwm_ch #(.CNT_W(CNT_W)) u_pwm_left (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cnt_next (w_cnt_next),
        .i_width    (w_width_l),
        .o_pwm      (signal_left)
    );

    servo_pwm_ch #(.CNT_W(CNT_W)) u_pwm_right (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cnt_next (w_cnt_next),
        .i_width    (w_width_r),
        .o_pwm      (signal_right)
    );

    assign busy       = (r_state == ST_RUN) || !w_empty;
    assign seg_done   = r_seg_done;
    assign fifo_count = r_count;
    assign frame_tick = w_tick;

endmodule

// File: tb/tb_servo_seq_pwm.sv
// Scoreboard bench for servo_seq_pwm: stimulus queues the expected per-frame pin
// high-times and seg_done counts, a frame monitor pops and compares at each frame_tick.
module tb_servo_seq_pwm;

    localparam int PER   = 100;
    localparam int POS   = 10;
    localparam int NEG   = 20;
    localparam int DEPTH = 4;
    localparam int DUR_W = 12;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_dir = 2'b00;
    logic [DUR_W-1:0] cmd_frames = '0;
    logic             abort = 1'b0;
    logic             cmd_ready;
    logic             signal_left;
    logic             signal_right;
    logic             busy;
    logic             seg_done;
    logic [2:0]       fifo_count;
    logic             frame_tick;

    servo_seq_pwm #(
        .PERIOD_CYC (PER),
        .PULSE_POS  (POS),
        .PULSE_NEG  (NEG),
        .DEPTH      (DEPTH),
        .DUR_W      (DUR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dir      (cmd_dir),
        .cmd_frames   (cmd_frames),
        .abort        (abort),
        .signal_left  (signal_left),
        .signal_right (signal_right),
        .busy         (busy),
        .seg_done     (seg_done),
        .fifo_count   (fifo_count),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hl;
        int hr;
        int nd;
    } frm_t;

    frm_t exp_q[$];
    int   pend_done = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    function automatic int wl(input int d);
        case (d)
            1:       return NEG;
            2, 3:    return POS;
            default: return 0;
        endcase
    endfunction

    function automatic int wr(input int d);
        case (d)
            1, 3:    return POS;
            2:       return NEG;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic exp_frame(input int hl, input int hr);
        exp_q.push_back('{hl, hr, pend_done});
        pend_done = 0;
    endtask

    task automatic exp_seg(input int d, input int n);
        int k = (n == 0) ? 1 : n;
        repeat (k) exp_frame(wl(d), wr(d));
        pend_done++;
    endtask

    task automatic exp_flush();
        if (pend_done > 0) exp_frame(0, 0);
    endtask

    // Frame monitor: per-frame high-time and seg_done tally, compared at frame_tick.
    initial begin : monitor
        int   acc_l = 0, acc_r = 0, acc_d = 0, per_cnt = 0, frame_no = 0;
        frm_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_l = 0; acc_r = 0; acc_d = 0; per_cnt = 0;
            end else begin
                acc_l += int'(signal_left);
                acc_r += int'(signal_right);
                acc_d += int'(seg_done);
                per_cnt++;
                if (frame_tick) begin
                    if (mon_en) begin
                        if (exp_q.size() > 0) e = exp_q.pop_front();
                        else                  e = '{0, 0, 0};
                        total++;
                        if (per_cnt != PER) begin
                            bad++;
                            $display("FAIL tick_period frame %0d: got %0d want %0d", frame_no, per_cnt, PER);
                        end
                        total++;
                        if (acc_l != e.hl || acc_r != e.hr || acc_d != e.nd) begin
                            bad++;
                            $display("FAIL frame %0d: got L=%0d R=%0d done=%0d want L=%0d R=%0d done=%0d",
                                     frame_no, acc_l, acc_r, acc_d, e.hl, e.hr, e.nd);
                        end
                    end
                    frame_no++;
                    acc_l = 0; acc_r = 0; acc_d = 0; per_cnt = 0;
                end
            end
        end
    end

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 250);
        #1;
        if (!frame_tick) begin
            total++;
            bad++;
            $display("FAIL tick_timeout: got none in %0d cycles want one", n);
        end
    endtask

    task automatic push(input int d, input int f);
        int n = 0;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_dir    = 2'(d);
        cmd_frames = DUR_W'(f);
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("push_ready", int'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            wait_tick();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // 1: reset state and idle frames
        repeat (3) @(posedge clk);
        #1;
        chk("rst_left", int'(signal_left), 0);
        chk("rst_right", int'(signal_right), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(seg_done), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_tick", int'(frame_tick), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (5) wait_tick();
        chk("idle_busy", int'(busy), 0);

        // 2: single forward segment
        wait_tick();
        exp_frame(0, 0); exp_seg(1, 3); exp_flush();
        push(1, 3);
        chk("t2_busy", int'(busy), 1);
        chk("t2_count", int'(fifo_count), 1);
        drain();

        // 3: back-to-back segments, zero-length treated as one frame
        wait_tick();
        push(2, 1); push(3, 2); push(0, 1); push(1, 0);
        exp_frame(0, 0); exp_seg(2, 1); exp_seg(3, 2); exp_seg(0, 1); exp_seg(1, 0); exp_flush();
        chk("t3_count", int'(fifo_count), 4);
        chk("t3_ready_full", int'(cmd_ready), 0);
        wait_tick();
        @(negedge clk);
        chk("t3_count_pop", int'(fifo_count), 3);
        chk("t3_busy", int'(busy), 1);
        drain();

        // 4: full FIFO refuses a push even in the pop cycle
        wait_tick();
        push(1, 1); push(2, 1); push(3, 1); push(0, 1);
        exp_frame(0, 0); exp_seg(1, 1); exp_seg(2, 1); exp_seg(3, 1); exp_seg(0, 1); exp_flush();
        chk("t4_count_full", int'(fifo_count), 4);
        wait_tick();
        chk("t4_ready_at_pop", int'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_dir = 2'd3; cmd_frames = DUR_W'(5);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t4_count_after_pop", int'(fifo_count), 3);
        chk("t4_ready_after_pop", int'(cmd_ready), 1);
        drain();

        // 5: abort mid-pulse, queued segments flushed, current pulse completes
        wait_tick();
        push(1, 5); push(2, 2); push(3, 2);
        exp_frame(0, 0); exp_frame(NEG, POS);
        wait_tick();
        repeat (5) @(negedge clk);
        chk("t5_mid_pulse", int'(signal_left), 1);
        abort = 1'b1;
        cmd_valid = 1'b1; cmd_dir = 2'd3; cmd_frames = DUR_W'(3);
        @(negedge clk);
        chk("t5_flushed", int'(fifo_count), 0);
        chk("t5_ready_abort", int'(cmd_ready), 0);
        chk("t5_busy_run", int'(busy), 1);
        cmd_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_push_lost", int'(fifo_count), 0);
        wait_tick();
        @(negedge clk);
        chk("t5_idle_busy", int'(busy), 0);
        chk("t5_pin_low", int'(signal_left), 0);
        drain();

        // 6: async reset mid-pulse
        wait_tick();
        push(3, 3);
        exp_frame(0, 0); exp_frame(POS, POS);
        wait_tick();
        repeat (5) @(negedge clk);
        chk("t6_mid_pulse", int'(signal_right), 1);
        mon_en = 1'b0;
        exp_q.delete();
        pend_done = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_left", int'(signal_left), 0);
        chk("t6_async_right", int'(signal_right), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("t6_count", int'(fifo_count), 0);
        chk("t6_busy", int'(busy), 0);
        mon_en = 1'b1;
        repeat (2) wait_tick();

        chk("exp_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
